// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared slot/mode/FSM enums, memory-map constants and the CPU access-lock rule
package gb_bus_pkg;
  typedef enum logic [1:0] {SLOT_CPU, SLOT_PPU, SLOT_MEM, SLOT_SETTLE} slot_t;
  typedef enum logic [1:0] {MODE_HBLANK, MODE_VBLANK, MODE_OAM, MODE_DRAW} ppu_mode_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic [1:0] {DIDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} dma_state_t;
  localparam logic [15:0] VRAM_LO = 16'h8000, VRAM_HI = 16'h9FFF;
  localparam logic [15:0] OAM_LO = 16'hFE00, OAM_HI = 16'hFE9F;
  localparam logic [15:0] HRAM_LO = 16'hFF80, HRAM_HI = 16'hFFFE;
  localparam logic [15:0] DMA_REG = 16'hFF46;
  localparam int OAM_LEN = 160;
  function automatic logic cpu_blocked(input logic [15:0] a, input ppu_mode_t m, input logic dma);
    cpu_blocked = (a >= VRAM_LO && a <= VRAM_HI && m == MODE_DRAW) ||
                  (a >= OAM_LO && a <= OAM_HI && (m == MODE_OAM || m == MODE_DRAW || dma)) ||
                  (dma && (a < HRAM_LO || a > HRAM_HI) && a != DMA_REG);
  endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: slot/PPU-mode inputs, CPU and PPU request ports, memory port and DMA status; master = requesters+memory side, slave = arbiter
interface bus_arbiter_if;
  import gb_bus_pkg::*;
  slot_t phase_in;
  logic phase_start_in;
  ppu_mode_t ppu_mode_in;
  logic cpu_req_in, cpu_we_in, cpu_ack_out;
  logic [15:0] cpu_addr_in;
  logic [7:0] cpu_wdata_in, cpu_rdata_out;
  logic ppu_req_in, ppu_data_valid_out;
  logic [15:0] ppu_addr_in;
  logic [7:0] ppu_data_out;
  logic mem_en_out, mem_we_out;
  logic [15:0] mem_addr_out;
  logic [7:0] mem_wdata_out, mem_rdata_in;
  logic dma_active_out;
  modport master (
    output phase_in, phase_start_in, ppu_mode_in, cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
           ppu_req_in, ppu_addr_in, mem_rdata_in,
    input cpu_rdata_out, cpu_ack_out, ppu_data_out, ppu_data_valid_out, mem_en_out, mem_we_out,
          mem_addr_out, mem_wdata_out, dma_active_out
  );
  modport slave (
    input phase_in, phase_start_in, ppu_mode_in, cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
          ppu_req_in, ppu_addr_in, mem_rdata_in,
    output cpu_rdata_out, cpu_ack_out, ppu_data_out, ppu_data_valid_out, mem_en_out, mem_we_out,
           mem_addr_out, mem_wdata_out, dma_active_out
  );
endinterface

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: one OAM DMA byte per MEM slot (read src+idx, write FE00+idx); ports slot_start_i/start_i/src_i/rdata_i in, next-cycle strobe en_o/we_o/addr_o/wdata_o and dma_active_out out
module oam_dma_engine
  import gb_bus_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        slot_start_i,
  input  logic        start_i,
  input  logic [7:0]  src_i,
  input  logic [7:0]  rdata_i,
  output logic        en_o,
  output logic        we_o,
  output logic [15:0] addr_o,
  output logic [7:0]  wdata_o,
  output logic        dma_active_out
);
  localparam logic [1:0] WLAST = 2'(MEM_LATENCY - 2);
  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d, src_q, src_d;
  logic [1:0] cnt_q, cnt_d;
  logic act_q, act_d, rd, wr, done;
  always_comb begin
    rd = state_q == DIDLE && act_q && slot_start_i;
    wr = (state_q == RD_ISSUE && MEM_LATENCY == 1) || (state_q == RD_WAIT && cnt_q == WLAST);
    done = state_q == WR_ISSUE;
    en_o = rd || wr;
    we_o = wr;
    addr_o = wr ? OAM_LO + {8'h00, idx_q} : {src_q, idx_q};
    wdata_o = rdata_i;
    state_d = state_q;
    case (state_q)
      DIDLE:    state_d = rd ? RD_ISSUE : DIDLE;
      RD_ISSUE: state_d = wr ? WR_ISSUE : RD_WAIT;
      RD_WAIT:  state_d = wr ? WR_ISSUE : RD_WAIT;
      default:  state_d = DIDLE;
    endcase
    cnt_d = state_q == RD_WAIT ? cnt_q + 2'd1 : 2'd0;
    idx_d = start_i ? 8'h00 : done ? idx_q + 8'd1 : idx_q;
    src_d = start_i ? src_i : src_q;
    act_d = start_i || (act_q && !(done && idx_q == 8'(OAM_LEN - 1)));
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= DIDLE;
      idx_q <= '0;
      src_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      src_q <= src_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end
  assign dma_active_out = act_q;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: slot-scheduled sharing of the memory port between CPU, PPU and OAM DMA with PPU-mode locks; ports clk_in, rst_in and the bus_arbiter_if slave bus
module bus_arbiter
  import gb_bus_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input logic clk_in,
  input logic rst_in,
  bus_arbiter_if.slave bus
);
  localparam logic [1:0] WLAST = 2'(MEM_LATENCY - 2);
  arb_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic own_cpu_q, blk_q, we_q;
  logic [15:0] addr_q;
  logic [7:0] wdata_q, cpu_rdata_q, ppu_data_q;
  logic mem_en_q, mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0] mem_wdata_q;
  logic cpu_go, ppu_go, start, blk_now, issue, cap, dma_start, mem_en_d;
  logic dma_en, dma_we, dma_active;
  logic [15:0] dma_addr;
  logic [7:0] dma_wdata;
  oam_dma_engine #(.MEM_LATENCY(MEM_LATENCY)) u_dma (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .slot_start_i(bus.phase_start_in && bus.phase_in == SLOT_MEM),
    .start_i(dma_start),
    .src_i(wdata_q),
    .rdata_i(bus.mem_rdata_in),
    .en_o(dma_en),
    .we_o(dma_we),
    .addr_o(dma_addr),
    .wdata_o(dma_wdata),
    .dma_active_out(dma_active)
  );
  always_comb begin
    cpu_go = bus.phase_in == SLOT_CPU && bus.cpu_req_in;
    ppu_go = bus.phase_in == SLOT_PPU && bus.ppu_req_in;
    start = state_q == IDLE && bus.phase_start_in && (cpu_go || ppu_go);
    blk_now = cpu_go && cpu_blocked(bus.cpu_addr_in, bus.ppu_mode_in, dma_active);
    issue = start && !blk_now;
    cap = (state_q == ISSUE && MEM_LATENCY == 1) || (state_q == WAIT && cnt_q == WLAST);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ISSUE : IDLE;
      ISSUE:   state_d = cap ? DONE : WAIT;
      WAIT:    state_d = cap ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
    cnt_d = state_q == WAIT ? cnt_q + 2'd1 : 2'd0;
    dma_start = state_q == DONE && own_cpu_q && we_q && !blk_q && addr_q == DMA_REG;
    mem_en_d = issue || dma_en;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      own_cpu_q <= 1'b0;
      blk_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rdata_q <= '0;
      ppu_data_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (start) begin
        own_cpu_q <= cpu_go;
        blk_q <= blk_now;
        we_q <= cpu_go && bus.cpu_we_in;
        addr_q <= cpu_go ? bus.cpu_addr_in : bus.ppu_addr_in;
        wdata_q <= bus.cpu_wdata_in;
      end
      if (cap && own_cpu_q) cpu_rdata_q <= blk_q ? 8'hFF : bus.mem_rdata_in;
      if (cap && !own_cpu_q) ppu_data_q <= bus.mem_rdata_in;
      mem_en_q <= mem_en_d;
      if (mem_en_d) begin
        mem_we_q <= dma_en ? dma_we : cpu_go && bus.cpu_we_in;
        mem_addr_q <= dma_en ? dma_addr : cpu_go ? bus.cpu_addr_in : bus.ppu_addr_in;
        mem_wdata_q <= dma_en ? dma_wdata : bus.cpu_wdata_in;
      end
    end
  end
  assign bus.cpu_ack_out = state_q == DONE && own_cpu_q;
  assign bus.ppu_data_valid_out = state_q == DONE && !own_cpu_q;
  assign bus.cpu_rdata_out = cpu_rdata_q;
  assign bus.ppu_data_out = ppu_data_q;
  assign bus.mem_en_out = mem_en_q;
  assign bus.mem_we_out = mem_we_q;
  assign bus.mem_addr_out = mem_addr_q;
  assign bus.mem_wdata_out = mem_wdata_q;
  assign bus.dma_active_out = dma_active;
endmodule
